// File: rtl/lvt_pkg.sv
// Shared LVT memory parameters: widths, lane count and saturating counter helper.
// Reused by the write dispatcher, the banked memory and the LVT itself.
package lvt_pkg;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;
    localparam int NLANE  = 8;
    localparam int LANE_W = $clog2(NLANE);
    localparam int CNT_W  = 16;

    function automatic logic [CNT_W-1:0] sat_add(
        input logic [CNT_W-1:0] a,
        input logic [CNT_W-1:0] b
    );
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/lvt_lane_fifo.sv
// Per-lane request FIFO holding {addr, data}; ready is a registered "not full",
// so it never depends on this cycle's push or pop.
module lvt_lane_fifo #(
    parameter int ADDR_W = lvt_pkg::ADDR_W,
    parameter int DATA_W = lvt_pkg::DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              ready,
    output logic              nonempty,
    output logic              empty_next,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_next;
    logic             do_push;
    logic             do_pop;

    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];

    assign do_push    = push & ready;
    assign do_pop     = pop & nonempty;
    assign nonempty   = (count != '0);
    assign empty_next = (count_next == '0);
    assign head_addr  = mem_addr[rd_ptr];
    assign head_data  = mem_data[rd_ptr];

    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + 1'b1;
        end else if (!do_push && do_pop) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            ready <= (count_next != (PTR_W+1)'(DEPTH));
        end
    end

    // Storage needs no reset: entries are only read while count is non-zero.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_addr[wr_ptr] <= push_addr;
            mem_data[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/lvt_write_dispatch.sv
// Multi-lane write dispatcher for an LVT memory: per-lane FIFOs feed dedicated
// write ports; equal-address heads are serialised by lane priority.
module lvt_write_dispatch #(
    parameter int ADDR_W = lvt_pkg::ADDR_W,
    parameter int DATA_W = lvt_pkg::DATA_W,
    parameter int NLANE  = lvt_pkg::NLANE,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NLANE-1:0]        in_valid,
    output logic [NLANE-1:0]        in_ready,
    input  logic [NLANE*ADDR_W-1:0] in_addr,
    input  logic [NLANE*DATA_W-1:0] in_data,
    output logic [NLANE-1:0]        w_enb,
    output logic [NLANE*ADDR_W-1:0] w_addr,
    output logic [NLANE*DATA_W-1:0] w_din,
    output logic                    idle,
    output logic [15:0]             conflict_cnt
);

    import lvt_pkg::*;

    // At most NLANE-1 lanes can be blocked in one cycle.
    localparam int BLK_W = (NLANE > (1 << LANE_W)) ?
                           $clog2(NLANE) + 1 : LANE_W + 1;

    logic [ADDR_W-1:0] head_addr [NLANE];
    logic [DATA_W-1:0] head_data [NLANE];
    logic [NLANE-1:0]  nonempty;
    logic [NLANE-1:0]  empty_next;
    logic [NLANE-1:0]  blocked;
    logic [NLANE-1:0]  issue;
    logic [BLK_W-1:0]  nblk;

    for (genvar i = 0; i < NLANE; i++) begin : g_lane
        lvt_lane_fifo #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk        (clk),
            .rst        (rst),
            .push       (in_valid[i]),
            .push_addr  (in_addr[i*ADDR_W +: ADDR_W]),
            .push_data  (in_data[i*DATA_W +: DATA_W]),
            .pop        (issue[i]),
            .ready      (in_ready[i]),
            .nonempty   (nonempty[i]),
            .empty_next (empty_next[i]),
            .head_addr  (head_addr[i]),
            .head_data  (head_data[i])
        );
    end

    always_comb begin
        blocked = '0;
        nblk    = '0;
        for (int i = 1; i < NLANE; i++) begin
            for (int j = 0; j < i; j++) begin
                if (nonempty[i] && nonempty[j] &&
                    head_addr[j] == head_addr[i]) begin
                    blocked[i] = 1'b1;
                end
            end
        end
        for (int i = 0; i < NLANE; i++) begin
            nblk = nblk + BLK_W'(blocked[i]);
        end
    end

    assign issue = nonempty & ~blocked;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_enb        <= '0;
            w_addr       <= '0;
            w_din        <= '0;
            idle         <= 1'b1;
            conflict_cnt <= '0;
        end else begin
            w_enb <= issue;
            for (int i = 0; i < NLANE; i++) begin
                if (issue[i]) begin
                    w_addr[i*ADDR_W +: ADDR_W] <= head_addr[i];
                    w_din[i*DATA_W +: DATA_W]  <= head_data[i];
                end
            end
            idle         <= (&empty_next) && !(|issue);
            conflict_cnt <= sat_add(conflict_cnt, CNT_W'(nblk));
        end
    end

endmodule

// File: tb/tb_lvt_write_dispatch.sv
// Self-checking bench for lvt_write_dispatch: directed table, corner sequences
// and random traffic against a queue-based reference model.
module tb_lvt_write_dispatch;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;
    localparam int NLANE  = 8;
    localparam int DEPTH  = 4;
    localparam int AW     = NLANE * ADDR_W;
    localparam int DW     = NLANE * DATA_W;

    logic             clk;
    logic             rst;
    logic [NLANE-1:0] in_valid;
    logic [NLANE-1:0] in_ready;
    logic [AW-1:0]    in_addr;
    logic [DW-1:0]    in_data;
    logic [NLANE-1:0] w_enb;
    logic [AW-1:0]    w_addr;
    logic [DW-1:0]    w_din;
    logic             idle;
    logic [15:0]      conflict_cnt;

    lvt_write_dispatch #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .NLANE  (NLANE),
        .DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_addr      (in_addr),
        .in_data      (in_data),
        .w_enb        (w_enb),
        .w_addr       (w_addr),
        .w_din        (w_din),
        .idle         (idle),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [ADDR_W-1:0] qa [NLANE][$];
    logic [DATA_W-1:0] qd [NLANE][$];
    logic [NLANE-1:0]  m_ready;
    logic [NLANE-1:0]  m_enb;
    logic [ADDR_W-1:0] m_addr [NLANE];
    logic [DATA_W-1:0] m_din [NLANE];
    int                m_cnt;
    logic              m_idle;

    typedef struct {
        logic [NLANE-1:0]  v;
        logic [AW-1:0]     a;
        logic [DW-1:0]     d;
        logic [NLANE-1:0]  e_enb;
        logic [NLANE-1:0]  e_rdy;
        logic              e_idle;
        logic [15:0]       e_cnt;
        int                lane;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_din;
    } vec_t;

    vec_t tv [7];

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] pa(input int l, input logic [ADDR_W-1:0] x);
        logic [AW-1:0] r;
        r = '0;
        r[l*ADDR_W +: ADDR_W] = x;
        return r;
    endfunction

    function automatic logic [DW-1:0] pd(input int l, input logic [DATA_W-1:0] x);
        logic [DW-1:0] r;
        r = '0;
        r[l*DATA_W +: DATA_W] = x;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NLANE; i++) begin
            qa[i].delete();
            qd[i].delete();
            m_addr[i] = '0;
            m_din[i]  = '0;
        end
        m_ready = '0;
        m_enb   = '0;
        m_cnt   = 0;
        m_idle  = 1'b1;
    endtask

    task automatic compare();
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        for (int i = 0; i < NLANE; i++) begin
            ea[i*ADDR_W +: ADDR_W] = m_addr[i];
            ed[i*DATA_W +: DATA_W] = m_din[i];
        end
        chk("in_ready", 256'(in_ready), 256'(m_ready));
        chk("w_enb", 256'(w_enb), 256'(m_enb));
        chk("w_addr", 256'(w_addr), 256'(ea));
        chk("w_din", 256'(w_din), 256'(ed));
        chk("idle", 256'(idle), 256'(m_idle));
        chk("conflict_cnt", 256'(conflict_cnt), 256'(m_cnt));
    endtask

    // One clock: drive inputs, advance model by the lane-priority rule, compare.
    task automatic cycle(input logic [NLANE-1:0] v, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        logic [NLANE-1:0] iss;
        logic [NLANE-1:0] acc;
        int               nblk;
        bit               all_empty;
        in_valid = v;
        in_addr  = a;
        in_data  = d;
        acc  = v & m_ready;
        iss  = '0;
        nblk = 0;
        for (int i = 0; i < NLANE; i++) begin
            if (qa[i].size() != 0) begin
                iss[i] = 1'b1;
                for (int j = 0; j < i; j++) begin
                    if (qa[j].size() != 0 && qa[j][0] == qa[i][0]) iss[i] = 1'b0;
                end
                if (!iss[i]) nblk++;
            end
        end
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < NLANE; i++) begin
                if (iss[i]) begin
                    m_addr[i] = qa[i].pop_front();
                    m_din[i]  = qd[i].pop_front();
                end
                if (acc[i]) begin
                    qa[i].push_back(a[i*ADDR_W +: ADDR_W]);
                    qd[i].push_back(d[i*DATA_W +: DATA_W]);
                end
            end
            m_enb = iss;
            m_cnt = (m_cnt + nblk > 65535) ? 65535 : m_cnt + nblk;
            all_empty = 1'b1;
            for (int i = 0; i < NLANE; i++) begin
                m_ready[i] = (qa[i].size() < DEPTH);
                if (qa[i].size() != 0) all_empty = 1'b0;
            end
            m_idle = all_empty && (iss == '0);
        end
        compare();
    endtask

    task automatic drain(input string nm);
        for (int c = 0; c < 40 && !m_idle; c++) cycle('0, '0, '0);
        chk(nm, 256'(idle), 256'(1));
    endtask

    initial begin
        logic [NLANE-1:0]  v;
        logic [AW-1:0]     a;
        logic [DW-1:0]     d;
        logic [ADDR_W-1:0] x;
        int                acc3;
        bit                pre;
        int                cnt0;

        rst      = 1'b0;
        in_valid = '0;
        in_addr  = '0;
        in_data  = '0;
        model_reset();
        #1 rst = 1'b1;
        #1;
        compare();
        cycle('0, '0, '0);
        cycle('0, '0, '0);
        rst = 1'b0;
        cycle('0, '0, '0);
        chk("rdy_after_reset", 256'(in_ready), 256'(8'hFF));

        // Directed table: single write latency, then a two-lane conflict.
        tv[0] = '{8'h01, pa(0, 11'h005), pd(0, 32'hA5A5A5A5),
                  8'h00, 8'hFF, 1'b0, 16'd0, -1, '0, '0};
        tv[1] = '{8'h00, '0, '0,
                  8'h01, 8'hFF, 1'b0, 16'd0, 0, 11'h005, 32'hA5A5A5A5};
        tv[2] = '{8'h00, '0, '0,
                  8'h00, 8'hFF, 1'b1, 16'd0, -1, '0, '0};
        tv[3] = '{8'h24, pa(2, 11'h010) | pa(5, 11'h010),
                  pd(2, 32'h22222222) | pd(5, 32'h55555555),
                  8'h00, 8'hFF, 1'b0, 16'd0, -1, '0, '0};
        tv[4] = '{8'h00, '0, '0,
                  8'h04, 8'hFF, 1'b0, 16'd1, 2, 11'h010, 32'h22222222};
        tv[5] = '{8'h00, '0, '0,
                  8'h20, 8'hFF, 1'b0, 16'd1, 5, 11'h010, 32'h55555555};
        tv[6] = '{8'h00, '0, '0,
                  8'h00, 8'hFF, 1'b1, 16'd1, -1, '0, '0};
        for (int r = 0; r < 7; r++) begin
            cycle(tv[r].v, tv[r].a, tv[r].d);
            chk($sformatf("tbl%0d_enb", r), 256'(w_enb), 256'(tv[r].e_enb));
            chk($sformatf("tbl%0d_rdy", r), 256'(in_ready), 256'(tv[r].e_rdy));
            chk($sformatf("tbl%0d_idle", r), 256'(idle), 256'(tv[r].e_idle));
            chk($sformatf("tbl%0d_cnt", r), 256'(conflict_cnt), 256'(tv[r].e_cnt));
            if (tv[r].lane >= 0) begin
                chk($sformatf("tbl%0d_addr", r),
                    256'(w_addr[tv[r].lane*ADDR_W +: ADDR_W]), 256'(tv[r].e_addr));
                chk($sformatf("tbl%0d_din", r),
                    256'(w_din[tv[r].lane*DATA_W +: DATA_W]), 256'(tv[r].e_din));
            end
        end

        // Lane 3 held by lane 0 conflicts fills up after four accepts.
        x    = 11'h0AA;
        acc3 = 0;
        for (int c = 0; c < 6; c++) begin
            v   = 8'h01 | ((acc3 < 5) ? 8'h08 : 8'h00);
            pre = m_ready[3];
            cycle(v, pa(0, x) | pa(3, x),
                  pd(0, 32'h0C000000 + 32'(c)) | pd(3, 32'h30000000 + 32'(acc3)));
            if (pre && v[3]) begin
                acc3++;
                if (acc3 == 4) chk("req038_full", 256'(in_ready[3]), 256'(0));
            end
        end
        chk("req038_held", 256'(acc3), 256'(4));
        for (int c = 0; c < 10 && acc3 < 5; c++) begin
            pre = m_ready[3];
            cycle(8'h08, pa(3, x), pd(3, 32'h30000004));
            if (pre) acc3++;
        end
        chk("req038_fifth", 256'(acc3), 256'(5));
        drain("req038_drain");

        // All lanes stream distinct addresses.
        cnt0 = m_cnt;
        for (int k = 0; k < 20; k++) begin
            a = '0;
            d = '0;
            for (int i = 0; i < NLANE; i++) begin
                a |= pa(i, ADDR_W'(i * 64 + k));
                d |= pd(i, {8'(i), 8'(k), 16'($urandom)});
            end
            cycle(8'hFF, a, d);
            if (k >= 1) chk($sformatf("req039_enb%0d", k), 256'(w_enb), 256'(8'hFF));
        end
        cycle('0, '0, '0);
        chk("req039_enb_last", 256'(w_enb), 256'(8'hFF));
        drain("req039_drain");
        chk("req039_cnt", 256'(conflict_cnt), 256'(cnt0));

        // Random traffic over a small address set to provoke conflicts.
        for (int c = 0; c < 1500; c++) begin
            v = NLANE'($urandom);
            if (c % 200 > 150) v = v & NLANE'($urandom);
            a = '0;
            d = '0;
            for (int i = 0; i < NLANE; i++) begin
                a |= pa(i, ADDR_W'($urandom_range(0, 3)));
                d |= pd(i, 32'($urandom));
            end
            cycle(v, a, d);
        end
        drain("rand_drain");

        // Reset with three entries queued on lane 1.
        x = 11'h123;
        for (int c = 0; c < 4; c++) begin
            v = 8'h01 | ((c < 3) ? 8'h02 : 8'h00);
            cycle(v, pa(0, x) | pa(1, x),
                  pd(0, 32'hD0D00000 + 32'(c)) | pd(1, 32'hB1B10000 + 32'(c)));
        end
        chk("req040_busy", 256'(w_enb), 256'(8'h01));
        in_valid = '0;
        rst      = 1'b1;
        #1;
        model_reset();
        chk("req040_enb_async", 256'(w_enb), 256'(0));
        compare();
        cycle('0, '0, '0);
        rst = 1'b0;
        cycle('0, '0, '0);
        chk("req040_rdy", 256'(in_ready), 256'(8'hFF));
        for (int c = 0; c < 5; c++) begin
            cycle('0, '0, '0);
            chk($sformatf("req040_stale%0d", c), 256'(w_enb), 256'(0));
        end

        // Every lane on one address: seven stalls per cycle until saturation.
        a = '0;
        for (int i = 0; i < NLANE; i++) a |= pa(i, 11'h7E7);
        for (int c = 0; c < 10000; c++) begin
            d = '0;
            for (int i = 0; i < NLANE; i++) d |= pd(i, 32'(c * 8 + i));
            cycle(8'hFF, a, d);
        end
        chk("req041_sat", 256'(conflict_cnt), 256'(16'hFFFF));
        drain("req041_drain");
        chk("req041_hold", 256'(conflict_cnt), 256'(16'hFFFF));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
